uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter, a bus responder on the CPU's byte-wide peripheral port (3-bit address, 8-bit data, we/re strobes), as produced by the memory I/O decoder. Accepts bytes from the CPU into a small FIFO and serializes them as 8N1 frames on `sout`. Exposes status and interrupt-enable registers, plus a level interrupt that requests more data when the FIFO drains. Complements the receive path by giving the CPU an independent, self-timed transmit channel.

## Interface
- `CLK_DIV`, 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of 2, ≥ 2.

- `clk`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `addr`  in  3: register select.
- `wr_data`  in  8: write data.
- `we`  in  1: write strobe, one access per cycle high.
- `re`  in  1: read strobe. No read side effects; accepted for bus compatibility.
- `rd_data`  out  8: read data, combinational from `addr`.
- `sout`  out  1: serial output, idle high.
- `intr`  out  1: level interrupt.

## Operation
- Register map (other addresses: write ignored, read 0x00):
  - addr 0: write pushes `wr_data[7:0]` into the FIFO. Reads return 0x00.
  - addr 1: STATUS, read. bit0 EMPTY (FIFO empty), bit1 FULL, bit2 IDLE (FIFO empty and FSM in IDLE), bit3 OVR (sticky overflow), bits7:4 = 0. Writing 1 to bit3 clears OVR; other bits ignored.
  - addr 2: CTRL, read/write. bit0 IEN; bits7:1 read 0.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle (count unchanged). Otherwise the byte is dropped and OVR is set.
- FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLK_DIV-1; bit index counts 0..7.
  - IDLE, FIFO non-empty: pop the head into the shift register, clear the counter, go to START.
  - START: `sout`=0 for CLK_DIV cycles, then DATA.
  - DATA: `sout` = shift[0], LSB first. Shift every CLK_DIV cycles. After bit 7 completes, go to STOP.
  - STOP: `sout`=1 for CLK_DIV cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (no gap). Otherwise go to IDLE.
- `intr` = IEN & EMPTY (level; no acknowledge beyond writing data or clearing IEN).
- `sout` is registered. No combinational path from `wr_data` to `sout`.

## Timing
- Reset values: `sout`=1, `intr`=0, FIFO empty, OVR=0, IEN=0, FSM=IDLE, STATUS reads 0x05.
- Reset is asynchronous mid-frame: `sout` goes to 1 immediately, and FIFO contents and the in-flight byte are discarded.
- Write at edge E0 with the FSM in IDLE: the pop occurs at E1, and `sout` falls at E1. The start bit spans E1..E1+CLK_DIV.
- Frame length is exactly 10×CLK_DIV cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Capacity: FIFO_DEPTH bytes queued plus 1 in the shifter. With FIFO_DEPTH=4 and the FSM idle, 5 consecutive writes are accepted and the 6th overflows.
- STATUS and `intr` reflect the registered state after each edge. EMPTY rises on the edge that pops the last entry.
- IDLE rises on the edge ending the final stop bit.
- A write and an OVR clear in the same cycle are not possible: there is one address per cycle.

## Test plan
- Reset: assert `reset` → `sout`=1, `intr`=0, read addr1 = 0x05, read addr2 = 0x00.
- Single frame (CLK_DIV=4): write 0xA5 to addr0 → `sout` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. STATUS = 0x05 exactly 40 cycles after the start bit begins.
- Overflow: 6 consecutive writes 0x01..0x06 while idle → 0x01..0x05 are sent back-to-back in 200 cycles with no gap, and 0x06 is never sent. STATUS bit3 = 1, and bit1 = 1 after the 6th write. Write 0x08 to addr1 → bit3 = 0.
- Full plus pop: fill to full, then write on the STOP final cycle → the byte is accepted, OVR stays 0, and it is later transmitted.
- Interrupt: write 0x01 to addr2 with the FIFO empty → `intr`=1. Write a byte → `intr`=0 after the push edge, and `intr`=1 again on the pop edge. Write 0x00 to addr2 → `intr`=0.
- Reset mid-frame: assert `reset` during DATA bit 3 → `sout`=1 immediately, STATUS = 0x05. After release, `sout` stays 1 with no residual frame.

Source files
------------

// File: rtl/uart_tx_port_if.sv
// Byte-wide peripheral bus between the CPU memory I/O decoder and the UART transmitter.
// The CPU side drives address, data and strobes; the peripheral returns read data.
interface uart_tx_port_if;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic       we;
  logic       re;
  logic [7:0] rd_data;

  modport master (output addr, wr_data, we, re, input rd_data);
  modport slave  (input addr, wr_data, we, re, output rd_data);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: a CPU-fed byte FIFO drains into a self-timed
// serializer, with STATUS/CTRL registers and a level "need data" interrupt.
module uart_tx_port #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_port_if.slave   bus,
  output logic            sout,
  output logic            intr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLK_DIV - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          ovr;
  logic          ien;

  logic fifo_empty, fifo_full, baud_done, pop, push_req, push, tx_idle;
  logic unused_re;

  assign unused_re  = bus.re;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == COUNT_FULL);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign tx_idle    = fifo_empty && (state == IDLE);

  // Pop either to start from idle or on the last stop-bit cycle so frames run back-to-back.
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign push_req = bus.we && (bus.addr == 3'd0);
  assign push     = push_req && (!fifo_full || pop);

  // NOTE: FIFO storage is deliberately not reset; validity is carried by count and pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ien    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && !push)
        ovr <= 1'b1;
      else if (bus.we && (bus.addr == 3'd1) && bus.wr_data[3])
        ovr <= 1'b0;
      if (bus.we && (bus.addr == 3'd2)) ien <= bus.wr_data[0];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      sout     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            sout     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            sout     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              sout  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              sout    <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_mem[rd_ptr];
              sout  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    bus.rd_data = 8'h00;
    case (bus.addr)
      3'd1:    bus.rd_data = {4'b0000, ovr, tx_idle, fifo_full, fifo_empty};
      3'd2:    bus.rd_data = {7'b0000000, ien};
      default: ;
    endcase
  end

  assign intr = ien & fifo_empty;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: stimulus queues expected bytes, a serial monitor
// decodes every frame on sout and compares it against the queue.
module tb_uart_tx_port;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk;
  logic reset;
  logic sout;
  logic intr;
  int   cyc;
  int   checks;
  int   failures;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  uart_tx_port_if bus ();

  uart_tx_port #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sout  (sout),
    .intr  (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr    = a;
    bus.wr_data = d;
    bus.we      = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.addr = 3'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    d        = bus.rd_data;
    bus.re   = 1'b0;
    bus.addr = 3'd0;
  endtask

  task automatic check_spacing(input string name);
    for (int i = 0; i + 1 < frame_starts.size(); i++)
      check(name, frame_starts[i + 1] - frame_starts[i], FRAME);
  endtask

  // Serial monitor: samples sout on every falling clock edge and decodes whole frames.
  initial begin
    logic [FRAME-1:0] smp;
    logic [7:0]       data;
    logic [7:0]       exp_b;
    logic             shape_ok;
    logic             aborted;
    int               start_cyc;
    forever begin
      @(negedge clk);
      if (!reset && sout === 1'b0) begin
        start_cyc = cyc;
        smp       = '0;
        smp[0]    = sout;
        aborted   = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          smp[k] = sout;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int s = 1; s < CLK_DIV; s++)
              if (smp[b*CLK_DIV+s] !== smp[b*CLK_DIV]) shape_ok = 1'b0;
          if (smp[0] !== 1'b0 || smp[9*CLK_DIV] !== 1'b1) shape_ok = 1'b0;
          for (int b = 0; b < 8; b++) data[b] = smp[(b+1)*CLK_DIV];
          check("frame_shape", shape_ok, 1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", data);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", data, exp_b);
          end
          frame_starts.push_back(start_cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] fill [6];
    int         zeros;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.addr    = 3'd0;
    bus.wr_data = 8'h00;
    bus.we      = 1'b0;
    bus.re      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_sout", sout, 1);
    check("reset_intr", intr, 0);
    bus_read(3'd1, d); check("reset_status", d, 8'h05);
    bus_read(3'd2, d); check("reset_ctrl", d, 8'h00);
    bus_read(3'd5, d); check("unmapped_read", d, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Single frame: 0xA5
    exp_q.push_back(8'hA5);
    bus_write(3'd0, 8'hA5);
    @(posedge clk); #1;
    check("start_fall", sout, 0);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    bus_read(3'd1, d); check("status_last_stop_cycle", d, 8'h01);
    @(posedge clk); #1;
    bus_read(3'd1, d); check("status_idle_after_frame", d, 8'h05);

    // Overflow: six writes, five accepted
    frame_starts.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) bus_write(3'd0, 8'(i));
    bus_read(3'd1, d); check("status_ovr_full", d, 8'h0A);
    bus_write(3'd1, 8'h08);
    bus_read(3'd1, d); check("status_ovr_cleared", d, 8'h02);
    repeat (240) @(posedge clk);
    #1;
    bus_read(3'd1, d); check("status_after_ovr_frames", d, 8'h05);
    check("ovr_frame_count", frame_starts.size(), 5);
    check_spacing("ovr_no_gap");

    // Full FIFO plus write on the stop-bit final cycle
    frame_starts.delete();
    fill = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E};
    for (int i = 0; i < 6; i++) exp_q.push_back(fill[i]);
    for (int i = 0; i < 5; i++) bus_write(3'd0, fill[i]);
    repeat (FRAME - 4) @(posedge clk);
    #1;
    bus_read(3'd1, d); check("status_full_before_pop", d, 8'h02);
    bus_write(3'd0, fill[5]);
    bus_read(3'd1, d); check("status_full_push_pop", d, 8'h02);
    repeat (240) @(posedge clk);
    #1;
    bus_read(3'd1, d); check("status_after_full_frames", d, 8'h05);
    check("full_frame_count", frame_starts.size(), 6);
    check_spacing("full_no_gap");

    // Interrupt
    bus_write(3'd2, 8'h01);
    check("intr_enabled", intr, 1);
    bus_read(3'd2, d); check("ctrl_read", d, 8'h01);
    exp_q.push_back(8'h5A);
    bus_write(3'd0, 8'h5A);
    check("intr_after_push", intr, 0);
    @(posedge clk); #1;
    check("intr_after_pop", intr, 1);
    bus_write(3'd2, 8'h00);
    check("intr_disabled", intr, 0);
    repeat (FRAME + 5) @(posedge clk);
    #1;
    bus_read(3'd1, d); check("status_after_intr_frame", d, 8'h05);

    // Reset mid-frame during data bit 3 of 0x96 (bit 3 = 0)
    bus_write(3'd0, 8'h96);
    repeat (18) @(posedge clk);
    #1;
    check("sout_data_bit3", sout, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midframe_reset_sout", sout, 1);
    bus_read(3'd1, d); check("midframe_reset_status", d, 8'h05);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (sout !== 1'b1) zeros++;
    end
    check("no_residual_frame", zeros, 0);
    bus_read(3'd1, d); check("status_after_reset_release", d, 8'h05);

    check("all_frames_sent", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
